stream_upsize: RTL and testbench

Width upsizer for the team's valid/ready byte-stream fabric, the counterpart of the downsizer. It collects `T_DATA_RATIO` consecutive narrow beats of `T_DATA_WIDTH` bits into one wide beat, with lane 0 filled first. A short packet closes the wide beat early when `s_last_i` is seen. A two-stage (accumulate + output) buffer sustains full input rate with no combinational ready path from master to slave.

---
 rtl/stream_upsize.sv | 134 +++++++++++++
 tb/tb_stream_upsize.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize.sv
// Narrow-to-wide valid/ready upsizer, lane 0 first; STREAM_UPSIZE_KEEP_EN adds the m_keep_o lane mask.
// Latency: closing narrow beat accepted at edge N -> wide beat valid right after edge N (output free).
// Backpressure: one full wide beat parks in the accumulator; s_ready_o is registered (!acc_full).
module stream_upsize #(
   parameter int T_DATA_WIDTH = 8,
   parameter int T_DATA_RATIO = 2
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [T_DATA_WIDTH-1:0]                    s_data_i,
   input  logic                                       s_last_i,
   input  logic                                       s_valid_i,
   output logic                                       s_ready_o,
   output logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]  m_data_o,
   output logic                                       m_last_o,
   output logic                                       m_valid_o,
`ifdef STREAM_UPSIZE_KEEP_EN
   output logic [T_DATA_RATIO-1:0]                    m_keep_o,
`endif
   input  logic                                       m_ready_i
);

   localparam int PW = $clog2(T_DATA_RATIO);
   localparam logic [PW-1:0] PTR_MAX = PW'(T_DATA_RATIO - 1);

   logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] acc;
   logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] acc_merged;
   logic [PW-1:0]                             ptr;
   logic                                      acc_full;
   logic                                      acc_last;

   logic write;
   logic read;
   logic out_free;
   logic closing;
   logic load_acc;
   logic load_in;

   assign s_ready_o = !acc_full;
   assign write     = s_valid_i & s_ready_o;
   assign read      = m_valid_o & m_ready_i;
   assign out_free  = !m_valid_o | m_ready_i;
   assign closing   = write & ((ptr == PTR_MAX) | s_last_i);
   // write is impossible while acc_full, so the two load sources never coincide
   assign load_acc  = acc_full & out_free;
   assign load_in   = closing & out_free;

   // Lanes above ptr are always zero, so a partial word is already zero-padded.
   always_comb begin
      acc_merged      = acc;
      acc_merged[ptr] = s_data_i;
   end

`ifdef STREAM_UPSIZE_KEEP_EN
   logic [T_DATA_RATIO-1:0] acc_keep;
   logic [T_DATA_RATIO-1:0] keep_merged;

   assign keep_merged = acc_keep | (T_DATA_RATIO'(1) << ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_keep <= '0;
         m_keep_o <= '0;
      end else begin
         if (load_acc) begin
            m_keep_o <= acc_keep;
         end else if (load_in) begin
            m_keep_o <= keep_merged;
         end
         if (load_acc) begin
            acc_keep <= '0;
         end else if (write) begin
            if (closing && out_free) begin
               acc_keep <= '0;
            end else begin
               acc_keep <= keep_merged;
            end
         end
      end
   end
`endif

   // Output stage: loads only when free, so data/last hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_o  <= '0;
         m_last_o  <= 1'b0;
         m_valid_o <= 1'b0;
      end else begin
         if (load_acc) begin
            m_data_o <= acc;
            m_last_o <= acc_last;
         end else if (load_in) begin
            m_data_o <= acc_merged;
            m_last_o <= s_last_i;
         end
         if (load_acc || load_in) begin
            m_valid_o <= 1'b1;
         end else if (read) begin
            m_valid_o <= 1'b0;
         end
      end
   end

   // Accumulator: collects lanes, parks a closed word when the output is busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         ptr      <= '0;
         acc_full <= 1'b0;
         acc_last <= 1'b0;
      end else begin
         if (load_acc) begin
            acc      <= '0;
            acc_full <= 1'b0;
            acc_last <= 1'b0;
         end else if (write) begin
            if (closing && out_free) begin
               acc <= '0;
               ptr <= '0;
            end else if (closing) begin
               acc      <= acc_merged;
               acc_last <= s_last_i;
               acc_full <= 1'b1;
               ptr      <= '0;
            end else begin
               acc[ptr] <= s_data_i;
               ptr      <= ptr + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_upsize.sv
// Directed bench for stream_upsize: R=4 and R=2 instances, scoreboard queues, immediate-assert checks.
module tb_stream_upsize;

   typedef struct packed {
      logic [31:0] d;
      logic        last;
      logic [3:0]  keep;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0]      s4_data;
   logic            s4_last, s4_valid, s4_ready;
   logic [3:0][7:0] m4_data;
   logic            m4_last, m4_valid, m4_ready;
   logic [3:0]      m4_keep;

   logic [7:0]      s2_data;
   logic            s2_last, s2_valid, s2_ready;
   logic [1:0][7:0] m2_data;
   logic            m2_last, m2_valid, m2_ready;
   logic [1:0]      m2_keep;

   int   tests = 0;
   int   fails = 0;
   exp_t q4[$];
   exp_t q2[$];
   exp_t e4, e2;

   stream_upsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(s4_data), .s_last_i(s4_last), .s_valid_i(s4_valid), .s_ready_o(s4_ready),
      .m_data_o(m4_data), .m_last_o(m4_last), .m_valid_o(m4_valid),
`ifdef STREAM_UPSIZE_KEEP_EN
      .m_keep_o(m4_keep),
`endif
      .m_ready_i(m4_ready)
   );

   stream_upsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(s2_data), .s_last_i(s2_last), .s_valid_i(s2_valid), .s_ready_o(s2_ready),
      .m_data_o(m2_data), .m_last_o(m2_last), .m_valid_o(m2_valid),
`ifdef STREAM_UPSIZE_KEEP_EN
      .m_keep_o(m2_keep),
`endif
      .m_ready_i(m2_ready)
   );

`ifndef STREAM_UPSIZE_KEEP_EN
   assign m4_keep = 4'h0;
   assign m2_keep = 2'h0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic put4(input logic [7:0] d, input logic l);
      int n = 0;
      s4_data = d; s4_last = l; s4_valid = 1'b1;
      while (!s4_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) check("put4_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s4_valid = 1'b0;
   endtask

   task automatic put2(input logic [7:0] d, input logic l, output int waited);
      int n = 0;
      s2_data = d; s2_last = l; s2_valid = 1'b1;
      while (!s2_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) check("put2_timeout", 32'd0, 32'd1);
      waited = n;
      @(posedge clk); #1;
      s2_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (m4_valid && m4_ready) begin
            if (q4.size() == 0) check("m4_unexpected_beat", 32'd1, 32'd0);
            else begin
               e4 = q4.pop_front();
               check("m4_data", m4_data, e4.d);
               check("m4_last", {31'd0, m4_last}, {31'd0, e4.last});
`ifdef STREAM_UPSIZE_KEEP_EN
               check("m4_keep", {28'd0, m4_keep}, {28'd0, e4.keep});
`endif
            end
         end
         if (m2_valid && m2_ready) begin
            if (q2.size() == 0) check("m2_unexpected_beat", 32'd1, 32'd0);
            else begin
               e2 = q2.pop_front();
               check("m2_data", {16'd0, m2_data}, e2.d);
               check("m2_last", {31'd0, m2_last}, {31'd0, e2.last});
`ifdef STREAM_UPSIZE_KEEP_EN
               check("m2_keep", {30'd0, m2_keep}, {28'd0, e2.keep});
`endif
            end
         end
      end
   end

   initial begin
      int w;
      rst_n = 1'b0;
      s4_data = '0; s4_last = 1'b0; s4_valid = 1'b0; m4_ready = 1'b1;
      s2_data = '0; s2_last = 1'b0; s2_valid = 1'b0; m2_ready = 1'b1;
      #12;
      check("rst_m4_valid", {31'd0, m4_valid}, 32'd0);
      check("rst_m4_data", m4_data, 32'd0);
      check("rst_m4_last", {31'd0, m4_last}, 32'd0);
      check("rst_s4_ready", {31'd0, s4_ready}, 32'd1);
      check("rst_m2_valid", {31'd0, m2_valid}, 32'd0);
      check("rst_s2_ready", {31'd0, s2_ready}, 32'd1);
`ifdef STREAM_UPSIZE_KEEP_EN
      check("rst_m4_keep", {28'd0, m4_keep}, 32'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      // R=4 full packet
      q4.push_back('{32'h44332211, 1'b1, 4'b1111});
      put4(8'h11, 1'b0); put4(8'h22, 1'b0); put4(8'h33, 1'b0); put4(8'h44, 1'b1);
      check("r4_full_latency", {31'd0, m4_valid}, 32'd1);

      // R=4 short packet, then next packet from lane 0
      q4.push_back('{32'h0000A2A1, 1'b1, 4'b0011});
      put4(8'hA1, 1'b0); put4(8'hA2, 1'b1);
      check("r4_short_valid", {31'd0, m4_valid}, 32'd1);
      check("r4_short_pad", m4_data, 32'h0000A2A1);
      q4.push_back('{32'hB4B3B2B1, 1'b1, 4'b1111});
      put4(8'hB1, 1'b0); put4(8'hB2, 1'b0); put4(8'hB3, 1'b0); put4(8'hB4, 1'b1);

      // R=2 continuous throughput
      for (int i = 1; i <= 8; i++) begin
         if (i % 2 == 1) q2.push_back('{{16'd0, 8'(i + 1), 8'(i)}, 1'b0, 4'b0011});
         put2(8'(i), 1'b0, w);
         check("r2_thru_no_stall", w, 32'd0);
         check("r2_thru_valid", {31'd0, m2_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;

      // R=2 backpressure
      m2_ready = 1'b0;
      q2.push_back('{32'h00000201, 1'b0, 4'b0011});
      put2(8'h01, 1'b0, w); put2(8'h02, 1'b0, w);
      q2.push_back('{32'h00000403, 1'b0, 4'b0011});
      put2(8'h03, 1'b0, w); put2(8'h04, 1'b0, w);
      check("bp_ready_low", {31'd0, s2_ready}, 32'd0);
      check("bp_valid_held", {31'd0, m2_valid}, 32'd1);
      q2.push_back('{32'h00000605, 1'b0, 4'b0011});
      s2_data = 8'h05; s2_last = 1'b0; s2_valid = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("bp_stall_ready", {31'd0, s2_ready}, 32'd0);
         check("bp_hold_data", {16'd0, m2_data}, 32'h00000201);
      end
      m2_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_drain_ready", {31'd0, s2_ready}, 32'd1);
      check("bp_drain_valid", {31'd0, m2_valid}, 32'd1);
      check("bp_drain_data", {16'd0, m2_data}, 32'h00000403);
      @(posedge clk); #1;
      s2_valid = 1'b0;
      put2(8'h06, 1'b0, w);

      // R=2 back-to-back single-beat packets
      for (int i = 1; i <= 3; i++) begin
         q2.push_back('{{24'd0, 8'(i * 16)}, 1'b1, 4'b0001});
         put2(8'(i * 16), 1'b1, w);
         check("single_no_bubble", {31'd0, m2_valid}, 32'd1);
         check("single_last", {31'd0, m2_last}, 32'd1);
      end

      // R=4 reset mid-packet with a pending output beat
      repeat (3) @(posedge clk);
      #1;
      m4_ready = 1'b0;
      put4(8'h61, 1'b0); put4(8'h62, 1'b0); put4(8'h63, 1'b0); put4(8'h64, 1'b1);
      put4(8'h55, 1'b0);
      check("pre_rst_pending", {31'd0, m4_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_m4_valid", {31'd0, m4_valid}, 32'd0);
      check("arst_m4_data", m4_data, 32'd0);
      check("arst_m4_last", {31'd0, m4_last}, 32'd0);
      check("arst_s4_ready", {31'd0, s4_ready}, 32'd1);
`ifdef STREAM_UPSIZE_KEEP_EN
      check("arst_m4_keep", {28'd0, m4_keep}, 32'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      m4_ready = 1'b1;
      q4.push_back('{32'h74737271, 1'b1, 4'b1111});
      put4(8'h71, 1'b0); put4(8'h72, 1'b0); put4(8'h73, 1'b0); put4(8'h74, 1'b1);
      check("post_rst_valid", {31'd0, m4_valid}, 32'd1);

      for (int n = 0; n < 20 && (q4.size() != 0 || q2.size() != 0); n++) @(posedge clk);
      #1;
      check("q4_drained", q4.size(), 32'd0);
      check("q2_drained", q2.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
